reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 182 ++++++++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU instructions until both operands are
// ready (capturing ALU/LSB broadcasts), then dispatches one per cycle, lowest index first.
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue_valid,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7,
    input  logic [31:0]          issue_val1,
    input  logic [31:0]          issue_val2,
    input  logic                 issue_rdy1,
    input  logic                 issue_rdy2,
    input  logic [ROB_POS_W-1:0] issue_tag1,
    input  logic [ROB_POS_W-1:0] issue_tag2,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    output logic                 rs_full,
    input  logic                 alu_res_valid,
    input  logic [ROB_POS_W-1:0] alu_res_rob_pos,
    input  logic [31:0]          alu_res_val,
    input  logic                 lsb_res_valid,
    input  logic [ROB_POS_W-1:0] lsb_res_rob_pos,
    input  logic [31:0]          lsb_res_val,
    output logic                 alu_en,
    output logic [ROB_POS_W-1:0] alu_rob_pos,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Handshake: issue_valid is accepted at any rdy edge with rs_full low (no ready
    // signal back to the decoder); alu_en is a one-cycle strobe the ALU always takes.
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   rdy1_q;
    logic [RS_SIZE-1:0]   rdy2_q;
    logic [ROB_POS_W-1:0] rob_pos_q [RS_SIZE];
    logic [6:0]           opcode_q  [RS_SIZE];
    logic [2:0]           funct3_q  [RS_SIZE];
    logic                 funct7_q  [RS_SIZE];
    logic [31:0]          val1_q    [RS_SIZE];
    logic [31:0]          val2_q    [RS_SIZE];
    logic [ROB_POS_W-1:0] tag1_q    [RS_SIZE];
    logic [ROB_POS_W-1:0] tag2_q    [RS_SIZE];
    logic [31:0]          imm_q     [RS_SIZE];
    logic [31:0]          pc_q      [RS_SIZE];

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             in_rdy1;
    logic             in_rdy2;
    logic [31:0]      in_val1;
    logic [31:0]      in_val2;

    assign rs_full = &busy;

    // Lowest-index free and lowest-index ready entries, from registered state only.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
            if (busy[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Same-cycle wakeup of operands arriving with the issue.
    always_comb begin
        in_rdy1 = issue_rdy1;
        in_val1 = issue_val1;
        in_rdy2 = issue_rdy2;
        in_val2 = issue_val2;
        if (!issue_rdy1) begin
            if (alu_res_valid && alu_res_rob_pos == issue_tag1) begin
                in_rdy1 = 1'b1;
                in_val1 = alu_res_val;
            end else if (lsb_res_valid && lsb_res_rob_pos == issue_tag1) begin
                in_rdy1 = 1'b1;
                in_val1 = lsb_res_val;
            end
        end
        if (!issue_rdy2) begin
            if (alu_res_valid && alu_res_rob_pos == issue_tag2) begin
                in_rdy2 = 1'b1;
                in_val2 = alu_res_val;
            end else if (lsb_res_valid && lsb_res_rob_pos == issue_tag2) begin
                in_rdy2 = 1'b1;
                in_val2 = lsb_res_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            alu_en      <= 1'b0;
            alu_rob_pos <= '0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
        end else if (rollback) begin
            busy   <= '0;
            alu_en <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rdy1_q[i]) begin
                    if (alu_res_valid && alu_res_rob_pos == tag1_q[i]) begin
                        rdy1_q[i] <= 1'b1;
                        val1_q[i] <= alu_res_val;
                    end else if (lsb_res_valid && lsb_res_rob_pos == tag1_q[i]) begin
                        rdy1_q[i] <= 1'b1;
                        val1_q[i] <= lsb_res_val;
                    end
                end
                if (busy[i] && !rdy2_q[i]) begin
                    if (alu_res_valid && alu_res_rob_pos == tag2_q[i]) begin
                        rdy2_q[i] <= 1'b1;
                        val2_q[i] <= alu_res_val;
                    end else if (lsb_res_valid && lsb_res_rob_pos == tag2_q[i]) begin
                        rdy2_q[i] <= 1'b1;
                        val2_q[i] <= lsb_res_val;
                    end
                end
            end

            alu_en <= sel_found;
            if (sel_found) begin
                busy[sel_idx] <= 1'b0;
                alu_rob_pos   <= rob_pos_q[sel_idx];
                alu_opcode    <= opcode_q[sel_idx];
                alu_funct3    <= funct3_q[sel_idx];
                alu_funct7    <= funct7_q[sel_idx];
                alu_val1      <= val1_q[sel_idx];
                alu_val2      <= val2_q[sel_idx];
                alu_imm       <= imm_q[sel_idx];
                alu_pc        <= pc_q[sel_idx];
            end

            // The free slot is never busy, so it cannot collide with the dispatched one.
            if (issue_valid && !rs_full) begin
                busy[free_idx]      <= 1'b1;
                rob_pos_q[free_idx] <= issue_rob_pos;
                opcode_q[free_idx]  <= issue_opcode;
                funct3_q[free_idx]  <= issue_funct3;
                funct7_q[free_idx]  <= issue_funct7;
                rdy1_q[free_idx]    <= in_rdy1;
                val1_q[free_idx]    <= in_val1;
                tag1_q[free_idx]    <= issue_tag1;
                rdy2_q[free_idx]    <= in_rdy2;
                val2_q[free_idx]    <= in_val2;
                tag2_q[free_idx]    <= issue_tag2;
                imm_q[free_idx]     <= issue_imm;
                pc_q[free_idx]      <= issue_pc;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, dispatch latency, wakeup paths,
// full/drain ordering, rollback, stall and mid-run reset.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        issue_valid;
    logic [3:0]  issue_rob_pos, issue_tag1, issue_tag2;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7, issue_rdy1, issue_rdy2;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        rs_full;
    logic        alu_res_valid, lsb_res_valid;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        alu_en, alu_funct7;
    logic [3:0]  alu_rob_pos;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_rob_pos(issue_rob_pos),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
        .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .rs_full(rs_full),
        .alu_res_valid(alu_res_valid), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res_valid(lsb_res_valid), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .alu_en(alu_en), .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        rollback      = 1'b0;
        alu_res_valid = 1'b0;
        lsb_res_valid = 1'b0;
    endtask

    task automatic issue_op(input logic [3:0] rob, input logic r1, input logic [3:0] t1,
                            input logic [31:0] v1, input logic r2, input logic [3:0] t2,
                            input logic [31:0] v2);
        issue_valid   = 1'b1;
        issue_rob_pos = rob;
        issue_opcode  = 7'h33;
        issue_funct3  = 3'd0;
        issue_funct7  = 1'b0;
        issue_rdy1    = r1;
        issue_tag1    = t1;
        issue_val1    = v1;
        issue_rdy2    = r2;
        issue_tag2    = t2;
        issue_val2    = v2;
        issue_imm     = 32'h0000_0004;
        issue_pc      = 32'h0000_1000 + {26'd0, rob, 2'b00};
    endtask

    task automatic broadcast_alu(input logic [3:0] tag, input logic [31:0] val);
        alu_res_valid   = 1'b1;
        alu_res_rob_pos = tag;
        alu_res_val     = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", alu_en); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", rs_full); end
        total++; if (alu_rob_pos !== 4'd0) begin bad++; $display("FAIL reset_rob got=%0d want=0", alu_rob_pos); end
        total++; if (alu_val1 !== 32'd0) begin bad++; $display("FAIL reset_val1 got=%0h want=0", alu_val1); end
    endtask

    task automatic test_ready_issue();
        issue_op(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL ready_e0_en got=%0b want=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL ready_en got=%0b want=1", alu_en); end
        total++; if (alu_rob_pos !== 4'd3) begin bad++; $display("FAIL ready_rob got=%0d want=3", alu_rob_pos); end
        total++; if (alu_val1 !== 32'd5) begin bad++; $display("FAIL ready_val1 got=%0h want=5", alu_val1); end
        total++; if (alu_val2 !== 32'd7) begin bad++; $display("FAIL ready_val2 got=%0h want=7", alu_val2); end
        total++; if (alu_opcode !== 7'h33) begin bad++; $display("FAIL ready_opcode got=%0h want=33", alu_opcode); end
        total++; if (alu_pc !== 32'h0000_100C) begin bad++; $display("FAIL ready_pc got=%0h want=100c", alu_pc); end
        total++; if (alu_imm !== 32'h4) begin bad++; $display("FAIL ready_imm got=%0h want=4", alu_imm); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL ready_after_en got=%0b want=0", alu_en); end
        total++; if (alu_rob_pos !== 4'd3) begin bad++; $display("FAIL ready_hold_rob got=%0d want=3", alu_rob_pos); end
    endtask

    task automatic test_wakeup();
        issue_op(4'd2, 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'd9);
        step();
        idle_inputs();
        lsb_res_valid   = 1'b1;
        lsb_res_rob_pos = 4'd7;
        lsb_res_val     = 32'h55;
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_wait_en got=%0b want=0", alu_en); end
        broadcast_alu(4'd1, 32'h10);
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_nomatch_en got=%0b want=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL wake_en got=%0b want=1", alu_en); end
        total++; if (alu_rob_pos !== 4'd2) begin bad++; $display("FAIL wake_rob got=%0d want=2", alu_rob_pos); end
        total++; if (alu_val1 !== 32'h10) begin bad++; $display("FAIL wake_val1 got=%0h want=10", alu_val1); end
        total++; if (alu_val2 !== 32'd9) begin bad++; $display("FAIL wake_val2 got=%0h want=9", alu_val2); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_after_en got=%0b want=0", alu_en); end
    endtask

    task automatic test_same_cycle_wakeup();
        issue_op(4'd6, 1'b1, 4'd0, 32'd1, 1'b0, 4'd5, 32'd0);
        lsb_res_valid   = 1'b1;
        lsb_res_rob_pos = 4'd5;
        lsb_res_val     = 32'hAB;
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL same_e0_en got=%0b want=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL same_en got=%0b want=1", alu_en); end
        total++; if (alu_rob_pos !== 4'd6) begin bad++; $display("FAIL same_rob got=%0d want=6", alu_rob_pos); end
        total++; if (alu_val2 !== 32'hAB) begin bad++; $display("FAIL same_val2 got=%0h want=ab", alu_val2); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL same_after_en got=%0b want=0", alu_en); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            issue_op(4'(i), 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'(i));
            step();
        end
        idle_inputs();
        total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b want=1", rs_full); end
        issue_op(4'd9, 1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF);
        step();
        idle_inputs();
        total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_drop_flag got=%0b want=1", rs_full); end
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL full_drop_en got=%0b want=0", alu_en); end
        broadcast_alu(4'd1, 32'h77);
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL full_wake_en got=%0b want=0", alu_en); end
        total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_wake_flag got=%0b want=1", rs_full); end
        for (int k = 0; k < 16; k++) begin
            step();
            total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL drain_en k=%0d got=%0b want=1", k, alu_en); end
            total++; if (alu_rob_pos !== 4'(k)) begin bad++; $display("FAIL drain_rob got=%0d want=%0d", alu_rob_pos, k); end
            total++; if (alu_val1 !== 32'h77) begin bad++; $display("FAIL drain_val1 k=%0d got=%0h want=77", k, alu_val1); end
            total++; if (alu_val2 !== 32'(k)) begin bad++; $display("FAIL drain_val2 got=%0h want=%0h", alu_val2, k); end
            if (k == 0) begin
                total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL drain_full got=%0b want=0", rs_full); end
            end
        end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL drain_done_en got=%0b want=0", alu_en); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL drain_done_full got=%0b want=0", rs_full); end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 4; i++) begin
            issue_op(4'(8 + i), 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd1);
            step();
        end
        issue_op(4'd12, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd3);
        step();
        idle_inputs();
        rollback = 1'b1;
        broadcast_alu(4'd3, 32'h1);
        step();
        idle_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_en got=%0b want=0", alu_en); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL rb_full got=%0b want=0", rs_full); end
        broadcast_alu(4'd3, 32'h1);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_after_en i=%0d got=%0b want=0", i, alu_en); end
            step();
        end
    endtask

    task automatic test_stall();
        issue_op(4'd5, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
        step();
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL stall_en i=%0d got=%0b want=0", i, alu_en); end
        end
        rdy = 1'b1;
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL stall_resume_en got=%0b want=1", alu_en); end
        total++; if (alu_rob_pos !== 4'd5) begin bad++; $display("FAIL stall_rob got=%0d want=5", alu_rob_pos); end
        total++; if (alu_val1 !== 32'h11) begin bad++; $display("FAIL stall_val1 got=%0h want=11", alu_val1); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL stall_after_en got=%0b want=0", alu_en); end
    endtask

    task automatic test_reset_mid();
        issue_op(4'd13, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd1);
        step();
        issue_op(4'd14, 1'b1, 4'd0, 32'h33, 1'b1, 4'd0, 32'h44);
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rstmid_en got=%0b want=0", alu_en); end
        total++; if (alu_rob_pos !== 4'd0) begin bad++; $display("FAIL rstmid_rob got=%0d want=0", alu_rob_pos); end
        total++; if (alu_val1 !== 32'd0) begin bad++; $display("FAIL rstmid_val1 got=%0h want=0", alu_val1); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%0b want=0", rs_full); end
        broadcast_alu(4'd4, 32'h9);
        step();
        idle_inputs();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rstmid_after_en got=%0b want=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rstmid_after2_en got=%0b want=0", alu_en); end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();
        issue_op(4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue_valid     = 1'b0;
        alu_res_rob_pos = 4'd0;
        alu_res_val     = 32'd0;
        lsb_res_rob_pos = 4'd0;
        lsb_res_val     = 32'd0;
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_same_cycle_wakeup();
        test_full();
        test_rollback();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
